// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI preset controller: message record,
// FSM state encoding and the channel-override helper.
package midi_pkg;

   localparam logic [7:0] CC_MSG = 8'hB0;
   localparam logic [7:0] PC_MSG = 8'hC0;

   typedef struct packed {
      logic [7:0] status;
      logic [7:0] data1;
      logic [7:0] data2;
      logic [1:0] len;
   } midi_msg_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      S_STAT,
      S_D1,
      S_D2
   } state_t;

   // Only channel-voice status bytes (0x80..0xEF) carry a channel nibble.
   function automatic logic [7:0] force_chan(input logic [7:0] status, input int fc);
      logic [7:0] res;
      res = status;
      if (fc != 0 && status >= 8'h80 && status <= 8'hEF) begin
         res = {status[7:4], 4'(fc - 1)};
      end
      return res;
   endfunction

endpackage

// File: rtl/midi_preset_ctrl_if.sv
// Bundles the button, receiver and byte-serial transmitter signals of the
// preset controller; the controller takes the slave view.
interface midi_preset_ctrl_if #(
   parameter int NUM_BUTTONS = 4
);
   logic [NUM_BUTTONS-1:0] btn_press;
   logic                   learn;
   logic                   clear_all;
   logic                   rx_valid;
   logic [7:0]             rx_status;
   logic [7:0]             rx_data1;
   logic [7:0]             rx_data2;
   logic [1:0]             rx_len;
   logic                   tx_valid;
   logic [7:0]             tx_byte;
   logic                   tx_ready;
   logic [NUM_BUTTONS-1:0] learned;
   logic                   armed;
   logic                   busy;

   modport master (
      output btn_press, learn, clear_all, rx_valid, rx_status, rx_data1, rx_data2, rx_len, tx_ready,
      input  tx_valid, tx_byte, learned, armed, busy
   );

   modport slave (
      input  btn_press, learn, clear_all, rx_valid, rx_status, rx_data1, rx_data2, rx_len, tx_ready,
      output tx_valid, tx_byte, learned, armed, busy
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping around.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     pending,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] grant,
   output logic             valid
);

   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!valid && pending[(int'(ptr) + k) % N]) begin
            valid = 1'b1;
            grant = IDX_W'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/midi_preset_ctrl.sv
// MIDI preset controller: per-button learned/default messages, round-robin
// playback queue, toggle mode, channel override, byte-level TX handshake.
//
// state  | meaning
// IDLE   | nothing in flight; waits for a pending press (playback mode only)
// LOAD   | grant a slot, latch its message
// S_STAT | offering status byte
// S_D1   | offering data1
// S_D2   | offering data2
module midi_preset_ctrl
   import midi_pkg::*;
#(
   parameter int                     NUM_BUTTONS   = 4,
   parameter logic [7:0]             BASE_CC       = 8'd46,
   parameter logic [NUM_BUTTONS-1:0] TOGGLE_MASK   = '0,
   parameter int                     FORCE_CHANNEL = 0
) (
   input  logic               clk,
   input  logic               rst,
   midi_preset_ctrl_if.slave  bus
);

   localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

   state_t                 state_q, state_d;
   logic [NUM_BUTTONS-1:0] pending_q, pending_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   midi_msg_t              msg_q, msg_d;
   midi_msg_t              slot_q [NUM_BUTTONS];
   midi_msg_t              slot_d [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] learned_q, learned_d;
   logic [NUM_BUTTONS-1:0] toggle_q, toggle_d;
   logic                   armed_q, armed_d;
   logic [IDX_W-1:0]       arm_idx_q, arm_idx_d;

   logic [IDX_W-1:0]       gnt_idx;
   logic                   gnt_valid;
   logic [IDX_W-1:0]       press_idx;
   midi_msg_t              sel_msg;
   logic                   hs;

   rr_arbiter #(.N(NUM_BUTTONS), .IDX_W(IDX_W)) u_arb (
      .pending (pending_q),
      .ptr     (rr_ptr_q),
      .grant   (gnt_idx),
      .valid   (gnt_valid)
   );

   always_comb begin
      press_idx = '0;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         if (bus.btn_press[i]) press_idx = IDX_W'(i);
      end
   end

   // Toggle-mode buttons zero data2 on every other grant, learned or not.
   always_comb begin
      sel_msg = slot_q[gnt_idx];
      if (!learned_q[gnt_idx]) begin
         sel_msg.status = CC_MSG;
         sel_msg.data1  = (BASE_CC + 8'(gnt_idx)) & 8'h7F;
         sel_msg.data2  = 8'h7F;
         sel_msg.len    = 2'd3;
      end
      if (TOGGLE_MASK[gnt_idx] && !toggle_q[gnt_idx]) sel_msg.data2 = 8'h00;
      sel_msg.status = force_chan(sel_msg.status, FORCE_CHANNEL);
   end

   always_comb begin
      bus.tx_valid = 1'b0;
      bus.tx_byte  = 8'h00;
      case (state_q)
         S_STAT: begin bus.tx_valid = 1'b1; bus.tx_byte = msg_q.status; end
         S_D1:   begin bus.tx_valid = 1'b1; bus.tx_byte = msg_q.data1;  end
         S_D2:   begin bus.tx_valid = 1'b1; bus.tx_byte = msg_q.data2;  end
         default: ;
      endcase
   end

   assign hs          = bus.tx_valid && bus.tx_ready;
   assign bus.learned = learned_q;
   assign bus.armed   = armed_q;
   assign bus.busy    = (state_q != IDLE) || (|pending_q);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      rr_ptr_d  = rr_ptr_q;
      msg_d     = msg_q;
      slot_d    = slot_q;
      learned_d = learned_q;
      toggle_d  = toggle_q;
      armed_d   = armed_q;
      arm_idx_d = arm_idx_q;

      case (state_q)
         IDLE: if ((|pending_q) && !bus.learn) state_d = LOAD;
         LOAD: begin
            if (gnt_valid) begin
               pending_d[gnt_idx] = 1'b0;
               rr_ptr_d = (int'(gnt_idx) == NUM_BUTTONS - 1) ? '0 : gnt_idx + 1'b1;
               msg_d    = sel_msg;
               if (TOGGLE_MASK[gnt_idx]) toggle_d[gnt_idx] = ~toggle_q[gnt_idx];
               state_d  = S_STAT;
            end else begin
               state_d = IDLE;
            end
         end
         S_STAT: if (hs) state_d = (msg_q.len >= 2'd2) ? S_D1 : IDLE;
         S_D1:   if (hs) state_d = (msg_q.len == 2'd3) ? S_D2 : IDLE;
         S_D2:   if (hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Applied after the grant so a press on the granted button queues it again.
      if (!bus.learn) pending_d = pending_d | bus.btn_press;

      if (bus.clear_all) begin
         learned_d = '0;
         toggle_d  = '1;
      end

      if (!bus.learn) begin
         armed_d = 1'b0;
      end else if (|bus.btn_press) begin
         armed_d   = 1'b1;
         arm_idx_d = press_idx;
      end else if (armed_q && bus.rx_valid && bus.rx_len != 2'd0) begin
         slot_d[arm_idx_q]    = '{status: bus.rx_status, data1: bus.rx_data1,
                                  data2: bus.rx_data2, len: bus.rx_len};
         learned_d[arm_idx_q] = 1'b1;
         armed_d              = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         rr_ptr_q  <= '0;
         msg_q     <= '0;
         learned_q <= '0;
         toggle_q  <= '1;
         armed_q   <= 1'b0;
         arm_idx_q <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) slot_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         msg_q     <= msg_d;
         learned_q <= learned_d;
         toggle_q  <= toggle_d;
         armed_q   <= armed_d;
         arm_idx_q <= arm_idx_d;
         slot_q    <= slot_d;
      end
   end

endmodule

// File: tb/tb_midi_preset_ctrl.sv
// Bench for midi_preset_ctrl: 4 buttons, button 1 in toggle mode, channel
// forced to 5 (channel-voice status bytes transmit with low nibble 4).
module tb_midi_preset_ctrl;
   import midi_pkg::*;

   localparam int NB = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   midi_preset_ctrl_if #(.NUM_BUTTONS(NB)) bus ();

   midi_preset_ctrl #(
      .NUM_BUTTONS(NB), .BASE_CC(8'd46), .TOGGLE_MASK(4'b0010), .FORCE_CHANNEL(5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [NB-1:0] btn;
      int            n;
      logic [7:0]    b0, b1, b2;
   } vec_t;

   vec_t       tbl_u [5];
   vec_t       tbl_l [5];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];

   always @(negedge clk) begin
      if (rst && bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_byte);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input logic [NB-1:0] m);
      bus.btn_press = m;
      tick();
      bus.btn_press = '0;
   endtask

   task automatic rx_msg(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [1:0] len);
      bus.rx_status = s; bus.rx_data1 = d1; bus.rx_data2 = d2; bus.rx_len = len;
      bus.rx_valid  = 1'b1;
      tick();
      bus.rx_valid  = 1'b0;
   endtask

   task automatic push_msg(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
      exp_q.push_back(b0);
      if (n >= 2) exp_q.push_back(b1);
      if (n == 3) exp_q.push_back(b2);
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while ((bus.busy || bus.tx_valid) && n < max) begin tick(); n++; end
      checks++;
      if (bus.busy || bus.tx_valid) begin
         errors++;
         $display("FAIL idle_timeout: busy=%0b expected 0", bus.busy);
      end
   endtask

   task automatic wait_valid(input int max);
      int n;
      n = 0;
      while (!bus.tx_valid && n < max) begin tick(); n++; end
      check("valid_timeout", 32'(bus.tx_valid), 32'd1);
   endtask

   task automatic drain(input string name);
      logic [7:0] e, g;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got no byte expected %02h", name, e);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL %s: got %02h expected %02h", name, g, e);
            end
         end
      end
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: got extra byte %02h expected none", name, g);
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      push_msg(v.n, v.b0, v.b1, v.b2);
      press(v.btn);
      wait_idle(60);
      drain(name);
   endtask

   initial begin
      // Unlearned defaults; button 1 toggle value alternates 00,7F after the first 7F.
      tbl_u[0] = '{btn: 4'b0010, n: 3, b0: 8'hB4, b1: 8'h2F, b2: 8'h00};
      tbl_u[1] = '{btn: 4'b0001, n: 3, b0: 8'hB4, b1: 8'h2E, b2: 8'h7F};
      tbl_u[2] = '{btn: 4'b0100, n: 3, b0: 8'hB4, b1: 8'h30, b2: 8'h7F};
      tbl_u[3] = '{btn: 4'b0010, n: 3, b0: 8'hB4, b1: 8'h2F, b2: 8'h7F};
      tbl_u[4] = '{btn: 4'b1000, n: 3, b0: 8'hB4, b1: 8'h31, b2: 8'h7F};
      // Learned playback; C0/90/93 forced to channel 5, F8 untouched.
      tbl_l[0] = '{btn: 4'b0001, n: 2, b0: 8'hC4, b1: 8'h42, b2: 8'h00};
      tbl_l[1] = '{btn: 4'b0100, n: 3, b0: 8'h94, b1: 8'h10, b2: 8'h20};
      tbl_l[2] = '{btn: 4'b1000, n: 1, b0: 8'hF8, b1: 8'h00, b2: 8'h00};
      tbl_l[3] = '{btn: 4'b0010, n: 3, b0: 8'h94, b1: 8'h3C, b2: 8'h00};
      tbl_l[4] = '{btn: 4'b0010, n: 3, b0: 8'h94, b1: 8'h3C, b2: 8'h64};

      bus.btn_press = '0; bus.learn = 1'b0; bus.clear_all = 1'b0; bus.rx_valid = 1'b0;
      bus.rx_status = '0; bus.rx_data1 = '0; bus.rx_data2 = '0; bus.rx_len = '0;
      bus.tx_ready  = 1'b1;

      tick(); tick();
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      rst = 1'b1;
      tick();
      check("reset_tx_byte", 32'(bus.tx_byte), 32'h00);
      check("reset_learned", 32'(bus.learned), 32'h0);
      check("reset_armed", 32'(bus.armed), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);

      // Press latency: valid two edges after the sampling edge.
      push_msg(3, 8'hB4, 8'h2F, 8'h7F);
      bus.btn_press = 4'b0010;
      tick();
      bus.btn_press = '0;
      check("lat_e0_valid", 32'(bus.tx_valid), 32'd0);
      check("lat_e0_busy", 32'(bus.busy), 32'd1);
      tick();
      check("lat_e1_valid", 32'(bus.tx_valid), 32'd0);
      tick();
      check("lat_e2_valid", 32'(bus.tx_valid), 32'd1);
      check("lat_e2_byte", 32'(bus.tx_byte), 32'hB4);
      wait_idle(60);
      drain("latency");

      for (int i = 0; i < 5; i++) run_vec(tbl_u[i], "unlearned_tbl");

      // Simultaneous 0+3 with rr_ptr wrapped to 0; a second press[3] coalesces.
      push_msg(3, 8'hB4, 8'h2E, 8'h7F);
      push_msg(3, 8'hB4, 8'h31, 8'h7F);
      press(4'b1001);
      tick();
      press(4'b1000);
      wait_idle(80);
      drain("simultaneous");

      bus.learn = 1'b1;
      press(4'b0001);
      check("learn_armed", 32'(bus.armed), 32'd1);
      check("learn_busy", 32'(bus.busy), 32'd0);
      rx_msg(PC_MSG, 8'h42, 8'h00, 2'd2);
      check("learn0_learned", 32'(bus.learned), 32'h1);
      check("learn0_disarm", 32'(bus.armed), 32'd0);

      bus.btn_press = 4'b0100;
      bus.rx_status = 8'h93; bus.rx_data1 = 8'h10; bus.rx_data2 = 8'h20; bus.rx_len = 2'd3;
      bus.rx_valid  = 1'b1;
      tick();
      bus.btn_press = '0; bus.rx_valid = 1'b0;
      check("same_cycle_learned", 32'(bus.learned), 32'h1);
      check("same_cycle_armed", 32'(bus.armed), 32'd1);
      rx_msg(8'h93, 8'h10, 8'h20, 2'd0);
      check("len0_learned", 32'(bus.learned), 32'h1);
      check("len0_armed", 32'(bus.armed), 32'd1);
      rx_msg(8'h93, 8'h10, 8'h20, 2'd3);
      check("learn2_learned", 32'(bus.learned), 32'h5);
      press(4'b1000);
      rx_msg(8'hF8, 8'h00, 8'h00, 2'd1);
      check("learn3_learned", 32'(bus.learned), 32'hD);
      press(4'b0010);
      rx_msg(8'h90, 8'h3C, 8'h64, 2'd3);
      check("learn1_learned", 32'(bus.learned), 32'hF);
      press(4'b0001);
      check("rearm_armed", 32'(bus.armed), 32'd1);
      bus.learn = 1'b0;
      tick();
      check("unlearn_disarm", 32'(bus.armed), 32'd0);
      check("unlearn_learned", 32'(bus.learned), 32'hF);

      for (int i = 0; i < 5; i++) run_vec(tbl_l[i], "learned_tbl");

      // Backpressure on the status byte.
      bus.tx_ready = 1'b0;
      push_msg(3, 8'h94, 8'h10, 8'h20);
      press(4'b0100);
      wait_valid(20);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 32'(bus.tx_valid), 32'd1);
         check("bp_byte", 32'(bus.tx_byte), 32'h94);
         tick();
      end
      bus.tx_ready = 1'b1;
      wait_idle(60);
      drain("backpressure");

      bus.clear_all = 1'b1;
      tick();
      bus.clear_all = 1'b0;
      check("clear_learned", 32'(bus.learned), 32'h0);
      run_vec(tbl_u[1], "after_clear0");
      run_vec(tbl_u[3], "after_clear1");

      // Reset while data1 is on the bus.
      bus.tx_ready = 1'b0;
      push_msg(1, 8'hB4, 8'h00, 8'h00);
      press(4'b0001);
      wait_valid(20);
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      check("mid_d1_byte", 32'(bus.tx_byte), 32'h2E);
      #2 rst = 1'b0;
      #1;
      check("rst_async_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_async_byte", 32'(bus.tx_byte), 32'h00);
      check("rst_async_busy", 32'(bus.busy), 32'd0);
      tick(); tick();
      rst = 1'b1;
      tick(); tick(); tick();
      check("post_rst_valid", 32'(bus.tx_valid), 32'd0);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      bus.tx_ready = 1'b1;
      drain("reset_mid");
      run_vec(tbl_u[1], "post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/midi_preset_ctrl.md
# midi_preset_ctrl

Parametrised MIDI preset controller: N debounced buttons each own a preset slot holding one learned 1–3-byte MIDI message, or a default CC message when unlearned. It sits between the button debouncer and MIDI receiver on one side and the byte-serial MIDI transmitter on the other. Additions over the previous controller:
- arbitrated queueing of simultaneous presses;
- a per-button toggle mode;
- optional channel override;
- a byte-level valid/ready TX handshake.

## Interface
- NUM_BUTTONS, 4, number of buttons/slots (2..16)
- BASE_CC, 8'd46, controller number of the default CC for button 0; button i uses BASE_CC+i (mod 128)
- TOGGLE_MASK, '0, bit i=1 puts button i in toggle mode
- FORCE_CHANNEL, 0, 0 = keep stored channel; 1..16 = replace the channel nibble of channel-voice status bytes (0x80–0xEF) with FORCE_CHANNEL-1 on transmit

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- btn_press  in  NUM_BUTTONS  single-cycle press pulses from the debouncer
- learn  in  1  level; 1 = learn mode
- clear_all  in  1  pulse; clears all learned flags
- rx_valid  in  1  single-cycle pulse; completed received message
- rx_status/rx_data1/rx_data2  in  8 each  received message bytes
- rx_len  in  2  received byte count, 0..3
- tx_valid  out  1  byte available
- tx_byte  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts byte
- learned  out  NUM_BUTTONS  slot i holds a learned message
- armed  out  1  a slot is waiting for a message in learn mode
- busy  out  1  state ≠ IDLE or pending ≠ 0

## Operation
- **Storage:** per-slot registers status, data1, data2, len (2 bits), learned flag, toggle bit.
- **Playback (learn=0):**
  - btn_press[i] sets pending[i].
  - A press while pending[i] is already set is coalesced into one transmission.
  - A press on the button currently being transmitted re-sets pending, so the message is sent again afterwards.
- **Arbitration:**
  - A round-robin arbiter picks the first set pending bit at or after rr_ptr.
  - Grant clears pending[g] and sets rr_ptr = g+1 (wraps to 0 after NUM_BUTTONS-1).
- **Message selection:**
  - Learned slot: the stored message, sending len bytes.
  - Unlearned slot: B0/BASE_CC+g/value, 3 bytes. value = 127, except for toggle-mode buttons, where value = 127 if toggle[g]=1, else 0.
  - The toggle bit flips on each grant of a toggle-mode button.
  - For learned toggle-mode slots, data2 alternates between the stored value and 0.
  - FORCE_CHANNEL is applied last, to status only.
- **FSM:**
  - IDLE → LOAD when any pending bit is set.
  - LOAD latches the message and goes to S_STAT.
  - S_STAT → S_D1 (if len ≥ 2) or IDLE, on handshake.
  - S_D1 → S_D2 (if len = 3) or IDLE, on handshake.
  - S_D2 → IDLE on handshake.
  - Handshake means tx_valid && tx_ready.
- **Learn (learn=1):**
  - btn_press[i] arms slot i and does not transmit. The lowest set index wins if several press in the same cycle; a later press re-arms a different slot.
  - The next rx_valid with rx_len ≠ 0 stores the message into the armed slot, sets learned[i] and disarms.
  - rx_len = 0 is ignored and the slot stays armed.
  - Deasserting learn disarms.
  - Transmissions already in flight complete; pending bits are not cleared.
- **clear_all:** clears every learned flag and resets toggle bits to 1. It does not affect a message already latched.

## Timing
- **Reset values:** tx_valid=0, tx_byte=0, learned=0, armed=0, busy=0; pending, rr_ptr and state (IDLE) reset; toggle bits=1; slot data=0.
- **Latency:**
  - Press sampled at edge E0 → pending set.
  - E1 → LOAD.
  - E2 → tx_valid=1 with the status byte.
  - The next message can start 2 cycles after the final handshake.
- **Handshake rules:**
  - tx_byte is stable while tx_valid=1 and not ready.
  - tx_valid drops the cycle after the last byte's handshake.
  - No combinational path from tx_ready to tx_valid.
- **Simultaneous events:**
  - rx_valid in the same cycle as the arming press: the message is not captured.
  - clear_all and a store in the same cycle: the store wins.
- **Reset mid-message:** all outputs go to reset values immediately (asynchronous), and the partial message is abandoned.

## Structure
- **midi_pkg:** status constants (CC_MSG=8'hB0, PC_MSG=8'hC0), typedef midi_msg_t {status, data1, data2, len}, and the FSM state enum.
- **rr_arbiter #(N):** sub-module with inputs pending and ptr, outputs grant index and valid.
- The slot array stays in the top module.

## Test plan
- **Unlearned press:** btn_press[1], tx_ready=1 → bytes B0, 2F, 7F; tx_valid first high 2 edges after the press.
- **Learn then play:**
  - learn=1, press[0], then rx_valid with C0/42, len 2 → learned[0]=1.
  - learn=0, press[0] → bytes C0, 42 only.
- **Simultaneous presses:** press[0] and press[3] together, rr_ptr=0 → message 0 then message 3. A repeated press[3] while pending → message 3 is sent once.
- **Toggle mode:** TOGGLE_MASK=4'b0010, press[1] three times → data2 sequence 7F, 00, 7F.
- **Backpressure and reset:**
  - tx_ready held 0 for 10 cycles → tx_byte stable throughout.
  - rst asserted during S_D1 → tx_valid=0 immediately; state IDLE after release.
- **Channel override:** FORCE_CHANNEL=5, learned status 0x93 → transmits 0x94. Learned status 0xF8 → unchanged.
